// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, port ids and
// direction constants.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic port_t other_port(input port_t p);
    return (p == PORT0) ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic; the pointer breaks ties when both request.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      pointer,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (enable) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (pointer == PORT1) ? 2'b10 : 2'b01;
        default: grant = '0;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between two requesters, one access per
// transaction, with a one-cycle ack and a per-port read data register.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DinLength = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 p0_req,
  input  logic                 p0_rw,
  input  logic [WIDTH-1:0]     p0_addr,
  input  logic [DinLength-1:0] p0_din,
  output logic                 p0_ack,
  output logic [DinLength-1:0] p0_dout,
  input  logic                 p1_req,
  input  logic                 p1_rw,
  input  logic [WIDTH-1:0]     p1_addr,
  input  logic [DinLength-1:0] p1_din,
  output logic                 p1_ack,
  output logic [DinLength-1:0] p1_dout,
  output logic                 mem_valid,
  output logic                 mem_rw,
  output logic [WIDTH-1:0]     mem_addr,
  output logic [DinLength-1:0] mem_din,
  input  logic [DinLength-1:0] mem_dout
);

  state_t     state;
  port_t      pointer;
  port_t      winner;
  logic [1:0] grant;
  logic       arb_enable;

  assign arb_enable = (state == IDLE);

  rr_arbiter2 u_arb (
    .req     ({p1_req, p0_req}),
    .pointer (pointer),
    .enable  (arb_enable),
    .grant   (grant)
  );

  // The mem_* registers double as the latched request, so they hold their
  // values outside ISSUE without a separate copy.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      pointer   <= PORT0;
      winner    <= PORT0;
      mem_valid <= 1'b0;
      mem_rw    <= RW_READ;
      mem_addr  <= '0;
      mem_din   <= '0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_dout   <= '0;
      p1_dout   <= '0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant[1]) begin
            winner    <= PORT1;
            mem_rw    <= p1_rw;
            mem_addr  <= p1_addr;
            mem_din   <= p1_din;
            mem_valid <= 1'b1;
            state     <= ISSUE;
          end else if (grant[0]) begin
            winner    <= PORT0;
            mem_rw    <= p0_rw;
            mem_addr  <= p0_addr;
            mem_din   <= p0_din;
            mem_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_valid <= 1'b0;
          if (mem_rw == RW_WRITE) begin
            p0_ack <= (winner == PORT0);
            p1_ack <= (winner == PORT1);
            state  <= DONE;
          end else begin
            state <= RDWAIT;
          end
        end
        RDWAIT: begin
          if (winner == PORT1) p1_dout <= mem_dout;
          else                 p0_dout <= mem_dout;
          p0_ack <= (winner == PORT0);
          p1_ack <= (winner == PORT1);
          state  <= DONE;
        end
        DONE: begin
          pointer <= other_port(winner);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read memory model attached
// to the mem_* port.
module tb_mem_arbiter;

  localparam int WIDTH = 8;
  localparam int DL    = 32;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             p0_req = 1'b0, p0_rw = 1'b0;
  logic [WIDTH-1:0] p0_addr = '0;
  logic [DL-1:0]    p0_din = '0;
  logic             p0_ack;
  logic [DL-1:0]    p0_dout;
  logic             p1_req = 1'b0, p1_rw = 1'b0;
  logic [WIDTH-1:0] p1_addr = '0;
  logic [DL-1:0]    p1_din = '0;
  logic             p1_ack;
  logic [DL-1:0]    p1_dout;
  logic             mem_valid, mem_rw;
  logic [WIDTH-1:0] mem_addr;
  logic [DL-1:0]    mem_din;
  logic [DL-1:0]    mem_dout = '0;

  logic [DL-1:0] mem [0:255];

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.WIDTH(WIDTH), .DinLength(DL)) dut (
    .Clk(Clk), .Reset(Reset),
    .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_din(p0_din),
    .p0_ack(p0_ack), .p0_dout(p0_dout),
    .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_din(p1_din),
    .p1_ack(p1_ack), .p1_dout(p1_dout),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 Clk = ~Clk;

  initial for (int i = 0; i < 256; i++) mem[i] = '0;

  always @(posedge Clk) begin
    if (mem_valid) begin
      if (mem_rw) mem[mem_addr] <= mem_din;
      else        mem_dout <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Reset  = 1'b1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  task automatic drive_port(input int port, input logic rw, input logic [WIDTH-1:0] a,
                            input logic [DL-1:0] d);
    if (port == 0) begin
      p0_rw = rw; p0_addr = a; p0_din = d; p0_req = 1'b1;
    end else begin
      p1_rw = rw; p1_addr = a; p1_din = d; p1_req = 1'b1;
    end
  endtask

  task automatic drop_port(input int port);
    if (port == 0) p0_req = 1'b0;
    else           p1_req = 1'b0;
  endtask

  // Cycle 0 is the IDLE cycle in which the request is first sampled.
  task automatic single_txn(input int port, input logic rw, input logic [WIDTH-1:0] a,
                            input logic [DL-1:0] d, input bit drop_early,
                            output int ack_cyc, output int valid_cnt, output logic rw_seen);
    ack_cyc   = -1;
    valid_cnt = 0;
    rw_seen   = 1'bx;
    drive_port(port, rw, a, d);
    for (int n = 1; n <= 10 && ack_cyc < 0; n++) begin
      tick();
      if (mem_valid) begin
        valid_cnt++;
        rw_seen = mem_rw;
      end
      if (drop_early && n == 1) drop_port(port);
      if ((port == 0 && p0_ack) || (port == 1 && p1_ack)) begin
        ack_cyc = n;
        drop_port(port);
      end
    end
    drop_port(port);
    tick();
  endtask

  task automatic run_pair(input logic rw0, input logic [WIDTH-1:0] a0, input logic [DL-1:0] d0,
                          input logic rw1, input logic [WIDTH-1:0] a1, input logic [DL-1:0] d1,
                          output int first, output int second);
    bit done0 = 1'b0, done1 = 1'b0;
    first  = -1;
    second = -1;
    drive_port(0, rw0, a0, d0);
    drive_port(1, rw1, a1, d1);
    for (int n = 0; n < 20 && !(done0 && done1); n++) begin
      tick();
      if (p0_ack && !done0) begin
        done0 = 1'b1; p0_req = 1'b0;
        if (first < 0) first = 0; else second = 0;
      end
      if (p1_ack && !done1) begin
        done1 = 1'b1; p1_req = 1'b0;
        if (first < 0) first = 1; else second = 1;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if ({mem_valid, mem_rw, mem_addr, mem_din} !== '0) begin
      fails++;
      $display("FAIL reset_mem_outputs: got valid=%b rw=%b addr=%h din=%h expected all 0",
               mem_valid, mem_rw, mem_addr, mem_din);
    end
    tests++;
    if ({p0_ack, p1_ack} !== 2'b00) begin
      fails++;
      $display("FAIL reset_acks: got %b%b expected 00", p0_ack, p1_ack);
    end
    tests++;
    if ({p0_dout, p1_dout} !== '0) begin
      fails++;
      $display("FAIL reset_douts: got %h/%h expected 0/0", p0_dout, p1_dout);
    end
  endtask

  task automatic test_write_read();
    int ack_cyc, vcnt;
    logic rws;
    single_txn(0, 1'b1, 8'h00, 32'hAABBCCDD, 1'b0, ack_cyc, vcnt, rws);
    tests++;
    if (ack_cyc !== 2) begin
      fails++; $display("FAIL wr_ack_cycle: got %0d expected 2", ack_cyc);
    end
    tests++;
    if (vcnt !== 1 || rws !== 1'b1) begin
      fails++; $display("FAIL wr_valid: got count=%0d rw=%b expected 1/1", vcnt, rws);
    end
    single_txn(0, 1'b0, 8'h00, 32'h0, 1'b0, ack_cyc, vcnt, rws);
    tests++;
    if (ack_cyc !== 3) begin
      fails++; $display("FAIL rd_ack_cycle: got %0d expected 3", ack_cyc);
    end
    tests++;
    if (vcnt !== 1 || rws !== 1'b0) begin
      fails++; $display("FAIL rd_valid: got count=%0d rw=%b expected 1/0", vcnt, rws);
    end
    tests++;
    if (p0_dout !== 32'hAABBCCDD) begin
      fails++; $display("FAIL rd_p0_dout: got %h expected aabbccdd", p0_dout);
    end
    tests++;
    if (p1_dout !== 32'h0) begin
      fails++; $display("FAIL rd_p1_dout_untouched: got %h expected 00000000", p1_dout);
    end
  endtask

  task automatic test_concurrent();
    int first, second, ack_cyc, vcnt;
    logic rws;
    apply_reset();
    run_pair(1'b1, 8'h01, 32'h11223344, 1'b1, 8'h02, 32'h55667788, first, second);
    tests++;
    if (first !== 0 || second !== 1) begin
      fails++; $display("FAIL conc_order: got %0d,%0d expected 0,1", first, second);
    end
    single_txn(0, 1'b0, 8'h01, 32'h0, 1'b0, ack_cyc, vcnt, rws);
    tests++;
    if (p0_dout !== 32'h11223344) begin
      fails++; $display("FAIL conc_rd01: got %h expected 11223344", p0_dout);
    end
    single_txn(1, 1'b0, 8'h02, 32'h0, 1'b0, ack_cyc, vcnt, rws);
    tests++;
    if (p1_dout !== 32'h55667788) begin
      fails++; $display("FAIL conc_rd02: got %h expected 55667788", p1_dout);
    end
  endtask

  task automatic test_back_to_back();
    int seq [5];
    int exp_seq [5] = '{0, 1, 0, 1, 0};
    int cnt = 0;
    apply_reset();
    drive_port(0, 1'b1, 8'h10, 32'h0000_0010);
    drive_port(1, 1'b1, 8'h20, 32'h0000_0020);
    for (int n = 0; n < 40 && cnt < 5; n++) begin
      tick();
      if (p0_ack) begin seq[cnt] = 0; cnt++; end
      if (p1_ack) begin seq[cnt] = 1; cnt++; end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    tests++;
    if (cnt !== 5) begin
      fails++; $display("FAIL b2b_ack_count: got %0d expected 5", cnt);
    end
    for (int i = 0; i < cnt; i++) begin
      tests++;
      if (seq[i] !== exp_seq[i]) begin
        fails++; $display("FAIL b2b_grant_%0d: got port %0d expected port %0d", i, seq[i], exp_seq[i]);
      end
    end
  endtask

  task automatic test_rw_order();
    int first, second, ack_cyc, vcnt;
    logic rws;
    single_txn(1, 1'b1, 8'h03, 32'h99AABBCC, 1'b0, ack_cyc, vcnt, rws);
    apply_reset();
    single_txn(0, 1'b0, 8'h00, 32'h0, 1'b0, ack_cyc, vcnt, rws);
    // pointer now names port 1, so p1's read goes ahead of p0's write
    run_pair(1'b1, 8'h03, 32'h0, 1'b0, 8'h03, 32'h0, first, second);
    tests++;
    if (first !== 1 || second !== 0) begin
      fails++; $display("FAIL order_ptr: got %0d,%0d expected 1,0", first, second);
    end
    tests++;
    if (p1_dout !== 32'h99AABBCC) begin
      fails++; $display("FAIL order_p1_dout: got %h expected 99aabbcc", p1_dout);
    end
    tests++;
    if (p0_dout !== 32'hAABBCCDD) begin
      fails++; $display("FAIL order_p0_dout_kept: got %h expected aabbccdd", p0_dout);
    end
    single_txn(1, 1'b0, 8'h03, 32'h0, 1'b0, ack_cyc, vcnt, rws);
    tests++;
    if (p1_dout !== 32'h0) begin
      fails++; $display("FAIL order_p1_reread: got %h expected 00000000", p1_dout);
    end
  endtask

  task automatic test_reset_midflight();
    int ack_cyc, vcnt, late_acks = 0;
    logic rws;
    drive_port(0, 1'b0, 8'h00, 32'h0);
    tick();
    tick();
    Reset  = 1'b1;
    p0_req = 1'b0;
    tick();
    tests++;
    if (p0_ack !== 1'b0) begin
      fails++; $display("FAIL midrst_ack: got %b expected 0", p0_ack);
    end
    tests++;
    if ({mem_valid, mem_rw, mem_addr, mem_din, p1_ack, p0_dout, p1_dout} !== '0) begin
      fails++;
      $display("FAIL midrst_outputs: got valid=%b rw=%b addr=%h din=%h p0_dout=%h p1_dout=%h expected all 0",
               mem_valid, mem_rw, mem_addr, mem_din, p0_dout, p1_dout);
    end
    Reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (p0_ack) late_acks++;
    end
    tests++;
    if (late_acks !== 0) begin
      fails++; $display("FAIL midrst_late_ack: got %0d expected 0", late_acks);
    end
    single_txn(1, 1'b1, 8'h05, 32'h12345678, 1'b0, ack_cyc, vcnt, rws);
    tests++;
    if (ack_cyc !== 2) begin
      fails++; $display("FAIL midrst_p1_wr_ack: got %0d expected 2", ack_cyc);
    end
    single_txn(1, 1'b0, 8'h05, 32'h0, 1'b0, ack_cyc, vcnt, rws);
    tests++;
    if (ack_cyc !== 3 || p1_dout !== 32'h12345678) begin
      fails++; $display("FAIL midrst_p1_rd: got cycle=%0d dout=%h expected 3/12345678", ack_cyc, p1_dout);
    end
  endtask

  task automatic test_drop_req();
    int ack_cyc, vcnt;
    logic rws;
    single_txn(0, 1'b1, 8'h04, 32'hDEADBEEF, 1'b1, ack_cyc, vcnt, rws);
    tests++;
    if (ack_cyc !== 2) begin
      fails++; $display("FAIL drop_ack: got %0d expected 2", ack_cyc);
    end
    single_txn(0, 1'b0, 8'h04, 32'h0, 1'b0, ack_cyc, vcnt, rws);
    tests++;
    if (p0_dout !== 32'hDEADBEEF) begin
      fails++; $display("FAIL drop_readback: got %h expected deadbeef", p0_dout);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_concurrent();
    test_back_to_back();
    test_rw_order();
    test_reset_midflight();
    test_drop_req();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
